power_pipe_2n: RTL
==================

Name: power_pipe_2n

Overview:
- Parametrised successor to the fixed three-stage power-of-8 pipeline.
- Computes x^(2^e) by repeated squaring, with the exponent e selectable per transaction (0..STAGES).
- Adds valid/ready backpressure with bubble collapsing and a per-result overflow flag.
- Sits in the arithmetic datapath between a streaming producer and a consumer that may stall.

Parameters:
- IN_W, 32, input operand width in bits; must satisfy 1 <= IN_W <= OUT_W.
- OUT_W, 64, datapath and result width in bits; every stage keeps the low OUT_W bits of its product.
- STAGES, 3, number of squaring stages; maximum exponent is 2^STAGES; must be >= 1.
- EXP_W, $clog2(STAGES+1), width of the exponent-select field.

Ports:
- clk  input  1  rising-edge clock; the block's only clock.
- reset_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- i_valid  input  1  input beat valid.
- o_ready  output  1  block can accept an input beat this cycle.
- i_value  input  IN_W  operand x, unsigned.
- i_exp  input  EXP_W  squaring count e; values > STAGES saturate to STAGES.
- o_valid  output  1  result beat valid.
- i_ready  input  1  consumer accepts the result this cycle.
- o_power  output  OUT_W  x^(2^e) mod 2^OUT_W.
- o_ovf  output  1  the true result did not fit in OUT_W bits.
- o_busy  output  1  at least one stage holds valid data.

Behaviour:
- Structure: STAGES register stages, S1..SSTAGES. Each stage holds vld, data[OUT_W], exp[EXP_W] and ovf.
- Input accept: an input beat transfers when i_valid && o_ready. On transfer:
  - data is loaded from the stage-1 combinational result on i_value zero-extended to OUT_W;
  - exp = min(i_exp, STAGES);
  - ovf = 0 before stage-1 evaluation.
- Stage k operation (k = 1..STAGES), with prod = d_in * d_in computed full width (2*OUT_W):
  - if exp_in >= k: d_out = prod[OUT_W-1:0] and ovf_out = ovf_in | (prod[2*OUT_W-1:OUT_W] != 0);
  - otherwise the stage passes data and ovf through unchanged.
  - exp travels with the data unchanged.
  - Exponent 0 returns x with ovf = 0.
- Handshake (bubble collapsing):
  - Stage k loads when !vld[k] || ready[k+1], where ready[STAGES+1] = i_ready.
  - o_ready = !vld[1] || ready[2].
  - A stage that loads without a valid upstream beat clears vld.
  - A stage that is neither loading nor draining holds all of its fields.
  - No beat is dropped or duplicated under any i_valid / i_ready pattern.
- Outputs and timing:
  - o_valid, o_power and o_ovf come directly from SSTAGES registers.
  - While o_valid && !i_ready, o_power and o_ovf are held stable.
- Latency and throughput:
  - Latency is exactly STAGES cycles from input transfer to o_valid when unstalled.
  - Latency is independent of e.
  - Throughput is 1 beat per cycle when i_ready is held high.
- Simultaneous events: a full pipeline with i_ready = 1 accepts a new input and emits a result in the same cycle (o_ready = 1).
- Stall: when the pipeline is full and i_ready = 0, o_ready = 0. Bubbles upstream of a stall still advance.
- o_busy = OR of all vld bits.
- Reset (synchronous, reset_n = 0 at a clk edge):
  - all vld = 0, data = 0, exp = 0, ovf = 0;
  - therefore o_valid = 0, o_power = 0, o_ovf = 0, o_busy = 0;
  - o_ready = 1 in the first cycle after reset is released.
  - A reset asserted mid-operation discards every in-flight beat; none emerge after release.
  - Inputs presented while reset_n = 0 are ignored.
- Arithmetic: all arithmetic is unsigned. Truncation applies only to the low OUT_W bits. o_ovf is sticky across stages for that beat only.

Test Plan:
- Default params, x=3, e=3, i_ready=1 -> o_valid exactly 3 cycles after transfer, o_power=6561, o_ovf=0; e=0,1,2 on the same x -> 3, 9, 81, all with latency 3.
- x=256, e=3 -> 2^64 truncated: o_power=0, o_ovf=1. x=0xFFFFFFFF, e=1 -> o_power=0xFFFFFFFE00000001, o_ovf=0. x=0xFFFFFFFF, e=2 -> o_ovf=1.
- Back-to-back stream x=1..20 with random e and i_ready=1 -> 20 results in order, one per cycle, each matching a reference model; e=7 behaves as e=3.
- Fill the pipeline, then drop i_ready for 5 cycles -> o_ready=0 once 3 beats are held; o_power stable while stalled; releasing i_ready yields all beats in order with no loss or duplication. Random i_valid/i_ready for 10k cycles -> scoreboard clean.
- Bubble collapse: a single beat in S3 with i_ready=0, then a new input -> o_ready stays 1 until S1..S3 are all valid.
- Assert reset_n=0 for 1 cycle with 2 beats in flight -> next cycle o_valid=0, o_busy=0, o_power=0, o_ready=1; no stale results appear afterwards.
- Params IN_W=16, OUT_W=32, STAGES=4, x=2, e=4 -> 2^16=65536 at latency 4; x=3, e=4 -> 3^16=43046721, o_ovf=0.

Source files
------------

// File: rtl/power_pipe_2n.sv
// ---------------------------------------------------------------------------
// power_pipe_2n
//
// Streaming repeated-squaring pipeline: computes x^(2^e) mod 2^OUT_W with a
// per-beat squaring count e (0..STAGES), valid/ready backpressure with
// bubble collapsing, and a sticky overflow flag that is set when any
// squaring of that beat loses significant bits.
//
// Parameters
//   IN_W    operand width (1 <= IN_W <= OUT_W)
//   OUT_W   datapath / result width
//   STAGES  number of squaring stages (>= 1); max exponent is 2^STAGES
//   EXP_W   width of the exponent-select field
//
// Ports
//   clk      rising-edge clock
//   reset_n  synchronous active-low reset
//   i_valid  input beat valid
//   o_ready  block can accept an input beat this cycle
//   i_value  operand x, unsigned
//   i_exp    squaring count e; values above STAGES saturate to STAGES
//   o_valid  result beat valid
//   i_ready  consumer accepts the result this cycle
//   o_power  x^(2^e) mod 2^OUT_W
//   o_ovf    true result did not fit in OUT_W bits
//   o_busy   at least one stage holds a valid beat
// ---------------------------------------------------------------------------
module power_pipe_2n #(
    parameter int IN_W   = 32,
    parameter int OUT_W  = 64,
    parameter int STAGES = 3,
    parameter int EXP_W  = $clog2(STAGES + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [IN_W-1:0]  i_value,
    input  logic [EXP_W-1:0] i_exp,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [OUT_W-1:0] o_power,
    output logic             o_ovf,
    output logic             o_busy
);

    localparam logic [EXP_W-1:0] MAX_EXP = EXP_W'(STAGES);

    // Full-width square of a datapath word; the upper half is kept so the
    // caller can detect bits lost by truncation.
    function automatic logic [2*OUT_W-1:0] square_full(input logic [OUT_W-1:0] d);
        logic [2*OUT_W-1:0] wide_v;
        wide_v = {{OUT_W{1'b0}}, d};
        return wide_v * wide_v;
    endfunction

    // Clamp a requested squaring count to the number of stages available.
    function automatic logic [EXP_W-1:0] sat_exp(input logic [EXP_W-1:0] e);
        logic [EXP_W-1:0] res_v;
        if (e > MAX_EXP) begin
            res_v = MAX_EXP;
        end else begin
            res_v = e;
        end
        return res_v;
    endfunction

    // Stage registers, index j holds stage j+1.
    logic [STAGES-1:0] vld_r;
    logic [OUT_W-1:0]  data_r [STAGES];
    logic [EXP_W-1:0]  exp_r  [STAGES];
    logic [STAGES-1:0] ovf_r;

    // Per-stage upstream view (what stage j would capture) and its result.
    logic [STAGES-1:0]  src_vld_s;
    logic [OUT_W-1:0]   src_data_s [STAGES];
    logic [EXP_W-1:0]   src_exp_s  [STAGES];
    logic [STAGES-1:0]  src_ovf_s;
    logic [2*OUT_W-1:0] prod_s     [STAGES];
    logic [OUT_W-1:0]   nxt_data_s [STAGES];
    logic [STAGES-1:0]  nxt_ovf_s;

    // Stage j may load this cycle.
    logic [STAGES-1:0]  ready_s;

    // Upstream sources: stage 1 sees the raw input beat, later stages see
    // the registers of the stage before them.
    always_comb begin
        src_vld_s     = {STAGES{1'b0}};
        src_ovf_s     = {STAGES{1'b0}};
        src_vld_s[0]  = i_valid;
        src_data_s[0] = OUT_W'(i_value);
        src_exp_s[0]  = sat_exp(i_exp);
        src_ovf_s[0]  = 1'b0;
        for (int j = 1; j < STAGES; j++) begin
            src_vld_s[j]  = vld_r[j-1];
            src_data_s[j] = data_r[j-1];
            src_exp_s[j]  = exp_r[j-1];
            src_ovf_s[j]  = ovf_r[j-1];
        end
    end

    // Stage arithmetic: stage j+1 squares only when the beat still needs at
    // least j+1 squarings; otherwise the beat passes through untouched so the
    // latency does not depend on the exponent.
    always_comb begin
        nxt_ovf_s = {STAGES{1'b0}};
        for (int j = 0; j < STAGES; j++) begin
            prod_s[j] = square_full(src_data_s[j]);
            if (src_exp_s[j] > EXP_W'(j)) begin
                nxt_data_s[j] = prod_s[j][OUT_W-1:0];
                nxt_ovf_s[j]  = src_ovf_s[j] | (prod_s[j][2*OUT_W-1:OUT_W] != {OUT_W{1'b0}});
            end else begin
                nxt_data_s[j] = src_data_s[j];
                nxt_ovf_s[j]  = src_ovf_s[j];
            end
        end
    end

    // Bubble-collapsing ready chain. Unrolling !vld[j] || ready[j+1] gives:
    // stage j may load if the consumer is ready or any stage from j to the
    // output is empty. Written in that form to keep the logic acyclic.
    always_comb begin
        logic all_full_v;
        ready_s = {STAGES{1'b0}};
        for (int j = 0; j < STAGES; j++) begin
            all_full_v = 1'b1;
            for (int m = 0; m < STAGES; m++) begin
                if (m >= j) begin
                    all_full_v = all_full_v & vld_r[m];
                end else begin
                    all_full_v = all_full_v;
                end
            end
            ready_s[j] = i_ready | ~all_full_v;
        end
    end

    // Stage registers: a loading stage captures its upstream beat or becomes
    // a bubble; a stage that is not loading keeps every field, which keeps
    // the output stable under a stall.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_r <= {STAGES{1'b0}};
            ovf_r <= {STAGES{1'b0}};
            for (int j = 0; j < STAGES; j++) begin
                data_r[j] <= {OUT_W{1'b0}};
                exp_r[j]  <= {EXP_W{1'b0}};
            end
        end else begin
            for (int j = 0; j < STAGES; j++) begin
                if (ready_s[j]) begin
                    if (src_vld_s[j]) begin
                        vld_r[j]  <= 1'b1;
                        data_r[j] <= nxt_data_s[j];
                        exp_r[j]  <= src_exp_s[j];
                        ovf_r[j]  <= nxt_ovf_s[j];
                    end else begin
                        vld_r[j]  <= 1'b0;
                    end
                end
            end
        end
    end

    // Result fields come straight from the last stage registers.
    assign o_valid = vld_r[STAGES-1];
    assign o_power = data_r[STAGES-1];
    assign o_ovf   = ovf_r[STAGES-1];
    assign o_ready = ready_s[0];
    assign o_busy  = |vld_r;

endmodule
